cursor_event_reader: RTL

- Consumer end of the cursor-position interface. Captures each position update, signalled by a one-cycle interrupt pulse with X/Y, into a small FIFO.
- Presents the oldest update to the processor-side register logic through a first-word-fall-through valid/read handshake.
- Provides a level interrupt, an occupancy count, a sticky overflow flag and a saturating drop counter, so software never misses or misorders cursor moves.

---
 rtl/cursor_event_reader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cursor_event_reader.sv
// Cursor-position event FIFO: captures X/Y updates on a one-cycle interrupt pulse and
// presents them first-word-fall-through. Optional macro CURSOR_EVENT_COALESCE_EN.
module cursor_event_reader #(
    parameter  int DEPTH = 8,
    parameter  int POS_W = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_intr,
    input  logic [POS_W-1:0] i_x_pos,
    input  logic [POS_W-1:0] i_y_pos,
    input  logic             i_rd_en,
    input  logic             i_clr_overflow,
    output logic             o_valid,
    output logic [POS_W-1:0] o_x,
    output logic [POS_W-1:0] o_y,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow,
    output logic [7:0]       o_drop_cnt,
    output logic             o_irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = 2 * POS_W;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [7:0]       drop_cnt;
    logic             irq;

    logic             full;
    logic             valid;
    logic             pop;
    logic             push;
    logic             drop;
    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;
    logic [CNT_W-1:0] count_next;
    logic             overflow_next;
    logic [7:0]       drop_cnt_next;
    logic [ENT_W-1:0] head;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    assign valid = (count != '0);
    assign pop   = i_rd_en & valid;
    // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
    assign push  = i_intr & (~full | pop);
    assign drop  = i_intr & full & ~pop;

    always_comb begin
        wr_en   = push;
        wr_addr = wptr;
`ifdef CURSOR_EVENT_COALESCE_EN
        // Overwrite the newest entry so software always sees the latest position.
        if (drop) begin
            wr_en   = 1'b1;
            wr_addr = wptr - PTR_W'(1);
        end
`endif
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // A drop in the same cycle as a clear wins: flag stays set, counter restarts at 1.
    always_comb begin
        overflow_next = overflow;
        drop_cnt_next = drop_cnt;
        if (drop) begin
            overflow_next = 1'b1;
            drop_cnt_next = i_clr_overflow ? 8'd1 : sat_inc8(drop_cnt);
        end else if (i_clr_overflow) begin
            overflow_next = 1'b0;
            drop_cnt_next = 8'd0;
        end
    end

    // Storage stage: data array is not reset, only the control state below.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {i_x_pos, i_y_pos};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
            irq      <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            count    <= count_next;
            overflow <= overflow_next;
            drop_cnt <= drop_cnt_next;
            irq      <= (count_next != '0) | overflow_next;
        end
    end

    assign head       = mem[rptr];
    assign o_valid    = valid;
    // Gate the head with valid so stale array contents never leak out after reset.
    assign o_x        = valid ? head[ENT_W-1:POS_W] : '0;
    assign o_y        = valid ? head[POS_W-1:0]     : '0;
    assign o_count    = count;
    assign o_overflow = overflow;
    assign o_drop_cnt = drop_cnt;
    assign o_irq      = irq;

endmodule
